// File: rtl/tw_seq_ctrl.sv
// tw_seq_ctrl: twiddle ROM read sequencer for a radix-2 DIT FFT
module tw_seq_ctrl #(
    parameter int stage_FFT = 10,
    parameter int STAGE_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   ready,
    output logic                   en_rd,
    output logic [stage_FFT-2:0]   rd_ptr_angle,
    output logic                   busy,
    output logic                   tw_valid,
    output logic [STAGE_W-1:0]     stage_tag,
    output logic [stage_FFT-2:0]   bf_tag,
    output logic                   stage_done,
    output logic                   done
);
    localparam int AW = stage_FFT - 1;
    localparam logic [STAGE_W-1:0] S_LAST = STAGE_W'(stage_FFT - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t            state, state_nx;
    logic [STAGE_W-1:0] s;
    logic [AW-1:0]     j, mask;
    logic              j_last, last;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next state, read enable and end-of-stage / end-of-frame flags
    always_comb begin
        j_last   = j == {AW{1'b1}};
        last     = j_last && s == S_LAST;
        en_rd    = state == RUN && ready;
        busy     = state != IDLE;
        state_nx = state == IDLE ? (start ? RUN : IDLE) :
                   state == RUN  ? (en_rd && last ? FLUSH : RUN) : IDLE;
    end

    // angle address: keep the low s bits of j, scaled up to the full ROM range
    always_comb begin
        mask         = (AW'(1) << s) - AW'(1);
        rd_ptr_angle = (j & mask) << (S_LAST - s);
    end

    // stage / butterfly counters, advanced on every accepted read
    always_ff @(posedge clk) begin
        if (rst || state != RUN) begin
            s <= '0;
            j <= '0;
        end else if (en_rd) begin
            j <= j + AW'(1);
            s <= last ? '0 : s + STAGE_W'(j_last);
        end
    end

    // tag pipeline aligned with the ROM's registered output
    always_ff @(posedge clk) begin
        if (rst) begin
            tw_valid   <= 1'b0;
            stage_done <= 1'b0;
            done       <= 1'b0;
            stage_tag  <= '0;
            bf_tag     <= '0;
        end else begin
            tw_valid   <= en_rd;
            stage_done <= en_rd && j_last;
            done       <= en_rd && last;
            if (en_rd) begin
                stage_tag <= s;
                bf_tag    <= j;
            end
        end
    end
endmodule

// File: tb/tb_tw_seq_ctrl.sv
// tb_tw_seq_ctrl: directed and table-driven checks of tw_seq_ctrl at N = 4, 16 and 1024
module tb_tw_seq_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic start2, ready2, en2, busy2, tv2, sd2, dn2;
    logic [0:0] addr2, bf2;
    logic [3:0] stg2;

    logic start4, ready4, en4, busy4, tv4, sd4, dn4;
    logic [2:0] addr4, bf4;
    logic [3:0] stg4;

    logic start10, ready10, en10, busy10, tv10, sd10, dn10;
    logic [8:0] addr10, bf10;
    logic [3:0] stg10;

    tw_seq_ctrl #(.stage_FFT(2), .STAGE_W(4)) u2 (
        .clk(clk), .rst(rst), .start(start2), .ready(ready2), .en_rd(en2),
        .rd_ptr_angle(addr2), .busy(busy2), .tw_valid(tv2), .stage_tag(stg2),
        .bf_tag(bf2), .stage_done(sd2), .done(dn2));

    tw_seq_ctrl #(.stage_FFT(4), .STAGE_W(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .ready(ready4), .en_rd(en4),
        .rd_ptr_angle(addr4), .busy(busy4), .tw_valid(tv4), .stage_tag(stg4),
        .bf_tag(bf4), .stage_done(sd4), .done(dn4));

    tw_seq_ctrl #(.stage_FFT(10), .STAGE_W(4)) u10 (
        .clk(clk), .rst(rst), .start(start10), .ready(ready10), .en_rd(en10),
        .rd_ptr_angle(addr10), .busy(busy10), .tw_valid(tv10), .stage_tag(stg10),
        .bf_tag(bf10), .stage_done(sd10), .done(dn10));

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        int st, rdy, en, addr, busy, tv, stg, bf, sd, dn;
    } vec_t;
    vec_t vt[15];

    int ntv4, ndone4, nsd4;
    logic [2:0] aq[$];

    task automatic mon4();
        logic [2:0] a;
        int s, j;
        if (tv4) begin
            a = aq.size() > 0 ? aq.pop_front() : 3'd0;
            s = ntv4 / 8;
            j = ntv4 % 8;
            if (ntv4 < 32) begin
                chk($sformatf("rnd%0d_stage", ntv4), int'(stg4), s);
                chk($sformatf("rnd%0d_bf", ntv4), int'(bf4), j);
                chk($sformatf("rnd%0d_addr", ntv4), int'(a), ((j & ((1 << s) - 1)) << (3 - s)) & 7);
            end
            ntv4++;
        end
        if (en4) aq.push_back(addr4);
        if (sd4) nsd4++;
        if (dn4) begin
            ndone4++;
            chk("rnd_done_with_last", ntv4, 32);
        end
    endtask

    initial begin
        int n_en, n_sd, n_dn, dn_cyc, tail;
        rst = 1'b1;
        start2 = 1'b0; ready2 = 1'b0;
        start4 = 1'b0; ready4 = 1'b0;
        start10 = 1'b0; ready10 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_en", int'(en2), 0);
        chk("rst_addr", int'(addr2), 0);
        chk("rst_busy", int'(busy2), 0);
        chk("rst_tv", int'(tv2), 0);
        chk("rst_stg", int'(stg2), 0);
        chk("rst_bf", int'(bf2), 0);
        chk("rst_sd", int'(sd2), 0);
        chk("rst_done", int'(dn2), 0);
        chk("rst_busy10", int'(busy10), 0);
        @(posedge clk); #1 rst = 1'b0;

        // N = 4: unstalled frame with ignored starts, then a stalled frame
        vt[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{0, 1, 1, 0, 1, 0, 0, 0, 0, 0};
        vt[2]  = '{0, 1, 1, 0, 1, 1, 0, 0, 0, 0};
        vt[3]  = '{1, 1, 1, 0, 1, 1, 0, 1, 1, 0};
        vt[4]  = '{0, 1, 1, 1, 1, 1, 1, 0, 0, 0};
        vt[5]  = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
        vt[6]  = '{1, 1, 0, 0, 0, 0, 1, 1, 0, 0};
        vt[7]  = '{0, 1, 1, 0, 1, 0, 1, 1, 0, 0};
        vt[8]  = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
        vt[9]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        vt[10] = '{0, 1, 1, 0, 1, 0, 0, 0, 0, 0};
        vt[11] = '{0, 1, 1, 0, 1, 1, 0, 1, 1, 0};
        vt[12] = '{0, 1, 1, 1, 1, 1, 1, 0, 0, 0};
        vt[13] = '{0, 1, 0, 0, 1, 1, 1, 1, 1, 1};
        vt[14] = '{0, 1, 0, 0, 0, 0, 1, 1, 0, 0};
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            start2 = 1'(vt[i].st);
            ready2 = 1'(vt[i].rdy);
            @(negedge clk);
            chk($sformatf("v%0d_en", i), int'(en2), vt[i].en);
            chk($sformatf("v%0d_addr", i), int'(addr2), vt[i].addr);
            chk($sformatf("v%0d_busy", i), int'(busy2), vt[i].busy);
            chk($sformatf("v%0d_tv", i), int'(tv2), vt[i].tv);
            chk($sformatf("v%0d_stg", i), int'(stg2), vt[i].stg);
            chk($sformatf("v%0d_bf", i), int'(bf2), vt[i].bf);
            chk($sformatf("v%0d_sd", i), int'(sd2), vt[i].sd);
            chk($sformatf("v%0d_done", i), int'(dn2), vt[i].dn);
        end
        @(posedge clk); #1 start2 = 1'b0;

        // N = 16: reset in cycle 3 of a run, then reset together with start
        start4 = 1'b1; ready4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("pre_rst_busy", int'(busy4), 1);
        chk("pre_rst_bf", int'(bf4), 1);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_en", int'(en4), 0);
        chk("mid_rst_addr", int'(addr4), 0);
        chk("mid_rst_busy", int'(busy4), 0);
        chk("mid_rst_tv", int'(tv4), 0);
        chk("mid_rst_stg", int'(stg4), 0);
        chk("mid_rst_bf", int'(bf4), 0);
        chk("mid_rst_sd", int'(sd4), 0);
        chk("mid_rst_done", int'(dn4), 0);
        @(posedge clk); #1 rst = 1'b1; start4 = 1'b1;
        @(posedge clk); #1 rst = 1'b0; start4 = 1'b0;
        @(negedge clk);
        chk("rst_start_busy", int'(busy4), 0);
        chk("rst_start_en", int'(en4), 0);

        // N = 16: random ready stalls must not disturb the read order
        ntv4 = 0; ndone4 = 0; nsd4 = 0; tail = 0;
        @(posedge clk); #1 start4 = 1'b1; ready4 = 1'($urandom_range(0, 1));
        @(negedge clk);
        mon4();
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1 start4 = 1'b0; ready4 = 1'($urandom_range(0, 1));
            @(negedge clk);
            mon4();
            if (ndone4 > 0) tail++;
            if (tail > 4) break;
        end
        chk("rnd_tv_count", ntv4, 32);
        chk("rnd_done_count", ndone4, 1);
        chk("rnd_sd_count", nsd4, 4);
        ready4 = 1'b0;

        // N = 1024: full unstalled frame with address spot checks
        n_en = 0; n_sd = 0; n_dn = 0; dn_cyc = -1;
        @(posedge clk); #1 start10 = 1'b1; ready10 = 1'b1;
        for (int c = 1; c <= 5125; c++) begin
            @(posedge clk); #1 start10 = 1'b0;
            @(negedge clk);
            if (en10) n_en++;
            if (sd10) n_sd++;
            if (dn10) begin
                n_dn++;
                dn_cyc = c;
            end
            if (c == 514)  chk("n1024_addr_s1_j1", int'(addr10), 256);
            if (c == 1542) chk("n1024_addr_s3_j5", int'(addr10), 320);
            if (c == 5120) chk("n1024_addr_s9_j511", int'(addr10), 511);
            if (c == 515) begin
                chk("n1024_stg_s1_j1", int'(stg10), 1);
                chk("n1024_bf_s1_j1", int'(bf10), 1);
            end
            if (c == 5121) begin
                chk("n1024_stg_last", int'(stg10), 9);
                chk("n1024_bf_last", int'(bf10), 511);
                chk("n1024_busy_flush", int'(busy10), 1);
            end
            if (c == 5122) chk("n1024_busy_idle", int'(busy10), 0);
        end
        chk("n1024_en_count", n_en, 5120);
        chk("n1024_sd_count", n_sd, 10);
        chk("n1024_done_count", n_dn, 1);
        chk("n1024_done_cycle", dn_cyc, 5121);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tw_seq_ctrl.md
# tw_seq_ctrl

Sequencer for the twiddle-factor ROMs of the radix-2 DIT FFT datapath. After a `start` pulse it walks every stage and butterfly of an N = 2^stage_FFT point transform. For each butterfly it drives the ROM read enable and angle address, honouring a downstream `ready` stall. It emits `tw_valid`, stage/butterfly tags and stage/frame completion pulses, all aligned with the ROM's 1-cycle registered output. It sits between the FFT top-level control and the `tw_factor_*` ROM instances.

## Interface
- `stage_FFT`, 10, log2 of FFT size N (≥ 2); ROM address width is stage_FFT-1.
- `STAGE_W`, 4, width of stage tag; must satisfy 2^STAGE_W ≥ stage_FFT.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: frame start request; sampled only in IDLE.
- `ready` in 1: downstream may accept next twiddle; low = stall.
- `en_rd` out 1: ROM read enable (combinational from state/`ready`).
- `rd_ptr_angle` out stage_FFT-1: ROM angle address (registered counters, combinational map).
- `busy` out 1: high from first RUN cycle through FLUSH.
- `tw_valid` out 1: ROM `cos_data`/`sin_data` are new this cycle (registered `en_rd`).
- `stage_tag` out STAGE_W: stage of data flagged by `tw_valid`.
- `bf_tag` out stage_FFT-1: butterfly index of data flagged by `tw_valid`.
- `stage_done` out 1: 1-cycle pulse with the last `tw_valid` of each stage.
- `done` out 1: 1-cycle pulse with the last `tw_valid` of the frame.

## Operation
- Counters: stage `s` (0..stage_FFT-1), butterfly `j` (0..N/2-1), both 0 at reset/IDLE.
- Address map: `rd_ptr_angle = (j & (2^s - 1)) << (stage_FFT-1-s)`, truncated to stage_FFT-1 bits. Stage 0 is always 0; the last stage equals `j`.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE: `busy` = 0, `en_rd` = 0. On `start` = 1, go to RUN with s = j = 0.
  - RUN: `en_rd = ready`. When `en_rd` = 1, j increments; when j = N/2-1 it wraps to 0 and s increments. On the read with s = stage_FFT-1 and j = N/2-1, go to FLUSH. When `ready` = 0, all counters hold and `en_rd` = 0.
  - FLUSH: one cycle, no read, then IDLE.
- Tag pipeline: registered on every cycle.
  - `tw_valid <= en_rd`.
  - `stage_tag <= s` and `bf_tag <= j` only when `en_rd`; otherwise they hold.
  - `stage_done <= en_rd & (j == N/2-1)`.
  - `done <= en_rd & last`.
- `start` outside IDLE is ignored; no queuing.
- Reset mid-frame: next cycle state = IDLE. Counters, `tw_valid`, tags, `stage_done`, `done` and `busy` are all 0. `en_rd` = 0 in the cycle after reset.
- Reset values: every output 0.
- Total reads per frame: stage_FFT × N/2.

## Timing
- `start` high in cycle 0, IDLE → RUN at the cycle-0 edge.
- With `ready` held high:
  - `en_rd` is high in cycles 1..R, where R = stage_FFT × N/2.
  - `tw_valid` is high in cycles 2..R+1.
  - `done` and `busy`'s last cycle fall in cycle R+1 (FLUSH).
  - IDLE resumes in cycle R+2, and a new `start` is accepted there.
- Read latency address → `tw_valid` = 1 cycle, matching the ROM's registered output.
- Each cycle of `ready` = 0 during RUN delays all subsequent events by one cycle.
- `ready` is ignored in FLUSH and IDLE.
- `start` and `rst` asserted together: reset wins.

## Test plan
- stage_FFT = 2, `ready` = 1, `start` at cycle 0:
  - `rd_ptr_angle` in cycles 1–4 = 0, 0, 0, 1.
  - (`stage_tag`, `bf_tag`) in cycles 2–5 = (0,0), (0,1), (1,0), (1,1).
  - `stage_done` in cycles 3 and 5; `done` in cycle 5; `busy` in cycles 1–5.
- stage_FFT = 2, `ready` = 0 in cycles 2–3:
  - Address 0 for (0,1) is held and `en_rd` = 0 in cycles 2–3.
  - `tw_valid` gap in cycles 3–4; `done` in cycle 7.
- stage_FFT = 10, `ready` = 1:
  - 5120 `en_rd` pulses, 10 `stage_done` pulses, `done` in cycle 5121.
  - Spot checks: stage 1, j = 1 → 256; stage 3, j = 5 → 320; stage 9, j = 511 → 511.
- `start` pulsed in cycles 3 and R+1 during a run: both ignored, exactly one `done`. A `start` in cycle R+2 starts a new frame.
- `rst` asserted at cycle 3 of a run:
  - Cycle 4: all outputs 0, state IDLE.
  - A subsequent `start` produces a full, correct frame from s = j = 0.
- Random `ready` (50 %) with stage_FFT = 4: the sequence of (`stage_tag`, `bf_tag`, ROM address) on `tw_valid` equals the unstalled reference order. The counts of `tw_valid` (32) and `done` (1) are exact.
